// File: rtl/decl_stream_arbiter.sv
// Two-requester front end for a shared declaration-checker engine: one statement per grant, verdict tagged with id.
// Optional DECL_MAXLEN_EN macro adds a MAX_LEN byte limit per statement (abort on overflow).
module decl_stream_arbiter #(
   parameter logic [7:0] IDLE_CHAR = 8'd32,
   parameter logic [7:0] TERM_CHAR = 8'd59
`ifdef DECL_MAXLEN_EN
   ,
   parameter int         MAX_LEN   = 64
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       r0_valid,
   input  logic [7:0] r0_data,
   output logic       r0_ready,
   input  logic       r1_valid,
   input  logic [7:0] r1_data,
   output logic       r1_ready,
   output logic [7:0] chk_in,
   output logic       chk_rst,
   input  logic       chk_out,
   output logic       res_valid,
   output logic       res_id,
   output logic       res_ok,
   output logic       err,
   output logic       busy
);

   // Handshake: a requester byte transfers on a cycle where its valid and ready are both high.
   typedef enum logic [1:0] {S_IDLE, S_FWD, S_WAIT, S_ABORT} state_t;

   state_t     state, state_nxt;
   logic       grant, grant_nxt;
   logic       rr_last, rr_last_nxt;
   logic       started, started_nxt;
   logic       g_valid;
   logic [7:0] g_data;

`ifdef DECL_MAXLEN_EN
   localparam int LW = $clog2(MAX_LEN + 1);
   logic [LW-1:0] len, len_nxt;
`endif

   assign g_valid = grant ? r1_valid : r0_valid;
   assign g_data  = grant ? r1_data  : r0_data;
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         grant   <= 1'b0;
         rr_last <= 1'b1;
         started <= 1'b0;
`ifdef DECL_MAXLEN_EN
         len     <= '0;
`endif
      end else begin
         state   <= state_nxt;
         grant   <= grant_nxt;
         rr_last <= rr_last_nxt;
         started <= started_nxt;
`ifdef DECL_MAXLEN_EN
         len     <= len_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant;
      rr_last_nxt = rr_last;
      started_nxt = started;
`ifdef DECL_MAXLEN_EN
      len_nxt     = len;
`endif
      case (state)
         S_IDLE: begin
            if (r0_valid || r1_valid) begin
               // Tie goes to whoever was not served last.
               grant_nxt   = (r0_valid && r1_valid) ? ~rr_last : r1_valid;
               state_nxt   = S_FWD;
               started_nxt = 1'b0;
`ifdef DECL_MAXLEN_EN
               len_nxt     = '0;
`endif
            end
         end
         S_FWD: begin
            if (g_valid) begin
               started_nxt = 1'b1;
`ifdef DECL_MAXLEN_EN
               len_nxt     = len + 1'b1;
`endif
               if (g_data == TERM_CHAR)
                  state_nxt = S_WAIT;
`ifdef DECL_MAXLEN_EN
               else if (len == LW'(MAX_LEN - 1))
                  state_nxt = S_ABORT;
`endif
            end else begin
               // A stall before the first byte is just a withdrawn request.
               state_nxt = started ? S_ABORT : S_IDLE;
            end
         end
         S_WAIT, S_ABORT: begin
            rr_last_nxt = grant;
            state_nxt   = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      r0_ready  = 1'b0;
      r1_ready  = 1'b0;
      chk_in    = IDLE_CHAR;
      chk_rst   = reset;
      res_valid = 1'b0;
      res_id    = 1'b0;
      res_ok    = 1'b0;
      err       = 1'b0;
      if (!reset) begin
         case (state)
            S_FWD: begin
               r0_ready = ~grant;
               r1_ready = grant;
               if (g_valid)
                  chk_in = g_data;
            end
            S_WAIT: begin
               res_valid = 1'b1;
               res_id    = grant;
               res_ok    = chk_out;
            end
            S_ABORT: begin
               chk_rst   = 1'b1;
               res_valid = 1'b1;
               res_id    = grant;
               err       = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_decl_stream_arbiter.sv
// Bench for decl_stream_arbiter: directed scenarios, then random two-source traffic against a statement-level model.
// Includes a behavioural declaration-checker engine driving chk_out.
module tb_decl_stream_arbiter;
   localparam logic [7:0] SP = 8'd32;
   localparam logic [7:0] TM = 8'd59;
`ifdef DECL_MAXLEN_EN
   localparam int MAXL = 8;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       r0_valid = 1'b0, r1_valid = 1'b0;
   logic [7:0] r0_data = 8'd0, r1_data = 8'd0;
   logic       r0_ready, r1_ready;
   logic [7:0] chk_in;
   logic       chk_rst;
   logic       chk_out;
   logic       res_valid, res_id, res_ok, err, busy;

   always #5 clk = ~clk;

`ifdef DECL_MAXLEN_EN
   decl_stream_arbiter #(.MAX_LEN(MAXL)) dut (
`else
   decl_stream_arbiter dut (
`endif
      .clk(clk), .reset(reset),
      .r0_valid(r0_valid), .r0_data(r0_data), .r0_ready(r0_ready),
      .r1_valid(r1_valid), .r1_data(r1_data), .r1_ready(r1_ready),
      .chk_in(chk_in), .chk_rst(chk_rst), .chk_out(chk_out),
      .res_valid(res_valid), .res_id(res_id), .res_ok(res_ok),
      .err(err), .busy(busy)
   );

   int         checks = 0;
   int         failures = 0;
   logic [2:0] exp_q[$];   // {id, ok, err}
   string      cur[2];
   int         pos[2];
   int         stall_at[2];
   int         gap[2];
   bit         active[2];
   int         left[2];
   logic       model_rr;
   bit         pick_pend;
   logic       pick_id;
   string      ebuf;
   string      pool[8];

   function automatic bit is_alpha(input byte c);
      return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || c == "_";
   endfunction

   // "int <identifier>" with optional surrounding spaces; terminator excluded.
   function automatic logic decl_ok(input string s);
      int i = 0;
      int n = s.len();
      while (i < n && s[i] == SP) i++;
      if (i + 4 > n) return 1'b0;
      if (s[i] != "i" || s[i+1] != "n" || s[i+2] != "t" || s[i+3] != SP) return 1'b0;
      i += 4;
      while (i < n && s[i] == SP) i++;
      if (i >= n || !is_alpha(s[i])) return 1'b0;
      while (i < n && (is_alpha(s[i]) || (s[i] >= "0" && s[i] <= "9"))) i++;
      while (i < n && s[i] == SP) i++;
      return (i == n);
   endfunction

   always @(posedge clk) begin
      if (chk_rst) begin
         ebuf    <= "";
         chk_out <= 1'b0;
      end else if (chk_in == TM) begin
         chk_out <= decl_ok(ebuf);
         ebuf    <= "";
      end else begin
         chk_out <= 1'b0;
         if (!(ebuf.len() == 0 && chk_in == SP))
            ebuf <= $sformatf("%s%c", ebuf, chk_in);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic load(input int r, input string s, input int g, input int st);
      cur[r] = s; pos[r] = 0; gap[r] = g; stall_at[r] = st; active[r] = 1'b1;
   endtask

   task automatic drive();
      string s;
      logic v;
      logic [7:0] d;
      for (int r = 0; r < 2; r++) begin
         v = 1'b0;
         d = (r == 0) ? r0_data : r1_data;
         if (active[r] && gap[r] == 0 && pos[r] != stall_at[r]) begin
            s = cur[r];
            v = 1'b1;
            d = s[pos[r]];
         end
         if (r == 0) begin r0_valid = v; r0_data = d; end
         else        begin r1_valid = v; r1_data = d; end
      end
   endtask

   task automatic observe();
      logic [2:0] e;
      bit         have;
      logic       acc;
      logic [7:0] d;
      string      s;
      have = 1'b0;
      e = 3'b000;
      if (res_valid && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         have = 1'b1;
         chk("res_id", res_id, e[2]);
         chk("res_ok", res_ok, e[1]);
         chk("err", err, e[0]);
         model_rr = e[2];
      end else begin
         chk("res_valid", res_valid, 0);
         chk("err_idle", err, 0);
      end
      chk("chk_rst", chk_rst, reset || (have && e[0]));
      chk("ready_excl", r0_ready & r1_ready, 0);
      if (pick_pend) begin
         chk("grant", pick_id ? r1_ready : r0_ready, 1);
         pick_pend = 1'b0;
      end
      if (!reset && !busy && (r0_valid || r1_valid)) begin
         pick_pend = 1'b1;
         pick_id = (r0_valid && r1_valid) ? ~model_rr : r1_valid;
      end
      if (r0_valid && r0_ready)      chk("chk_in", chk_in, r0_data);
      else if (r1_valid && r1_ready) chk("chk_in", chk_in, r1_data);
      else                           chk("chk_in_idle", chk_in, SP);
      for (int r = 0; r < 2; r++) begin
         acc = (r == 0) ? (r0_valid && r0_ready) : (r1_valid && r1_ready);
         d   = (r == 0) ? r0_data : r1_data;
         if (!active[r]) continue;
         if (gap[r] > 0) gap[r]--;
         else if (pos[r] == stall_at[r]) begin
            exp_q.push_back({(r == 1), 1'b0, 1'b1});
            active[r] = 1'b0;
         end else if (acc) begin
            pos[r]++;
            s = cur[r];
            if (d == TM) begin
               exp_q.push_back({(r == 1), decl_ok(s.substr(0, s.len() - 2)), 1'b0});
               active[r] = 1'b0;
            end
`ifdef DECL_MAXLEN_EN
            else if (pos[r] == MAXL) begin
               exp_q.push_back({(r == 1), 1'b0, 1'b1});
               active[r] = 1'b0;
            end
`endif
         end
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
      drive();
      #2;
      observe();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      active[0] = 1'b0; active[1] = 1'b0;
      pick_pend = 1'b0;
      drive();
      #2;
      observe();
      chk("rst_chk_rst", chk_rst, 1);
      chk("rst_ready", {r0_ready, r1_ready}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_rr = 1'b1;
      pick_pend = 1'b0;
      exp_q.delete();
      drive();
      #2;
      observe();
      chk("rst_busy", busy, 0);
      chk("rst_outs", {r0_ready, r1_ready, res_valid, res_id, res_ok, err, chk_rst}, 0);
      chk("rst_chk_in", chk_in, SP);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   done;
      pool = '{"int a;", "int xy;", "int 1;", "in x;", ";", "int ;", "int b_2;", "int  q;"};
      active[0] = 1'b0; active[1] = 1'b0;
      model_rr = 1'b1;
      pick_pend = 1'b0;
      do_reset();

      // Single requester, clean statement.
      load(0, "int a;", 0, -1);
      for (int k = 0; k <= 7; k++) begin
         step();
         chk("t1_ready", r0_ready, (k >= 1 && k <= 6));
         chk("t1_res_valid", res_valid, (k == 7));
         if (k == 7) chk("t1_ok", {res_id, res_ok}, 2'b01);
      end

      // Contention from reset: r0 first, r1 after one idle cycle.
      do_reset();
      load(0, "int x;", 0, -1);
      load(1, "int 1;", 0, -1);
      for (int k = 0; k <= 15; k++) begin
         step();
         chk("t2_res_valid", res_valid, (k == 7 || k == 15));
         chk("t2_r1_ready", r1_ready, (k >= 9 && k <= 14));
         if (k == 8)  chk("t2_gap_idle", busy, 0);
         if (k == 15) chk("t2_r1_verdict", {res_id, res_ok}, 2'b10);
      end

      // Mid-statement stall from r1, then a clean statement from r0.
      load(1, "int a;", 0, 5);
      for (int k = 0; k <= 7; k++) begin
         step();
         chk("t3_err", err, (k == 7));
      end
      load(0, "int b;", 0, -1);
      for (int k = 0; k <= 7; k++) begin
         step();
         if (k == 7) chk("t3_after_abort", {res_valid, res_id, res_ok}, 3'b101);
      end

      // Request withdrawn before any byte is accepted.
      for (int k = 0; k <= 3; k++) begin
         @(posedge clk); #1;
         drive();
         if (k == 0) begin r0_valid = 1'b1; r0_data = "q"; end
         #2;
         observe();
         chk("t4_busy", busy, (k == 1));
         chk("t4_quiet", {res_valid, err}, 0);
      end

      // Reset in the middle of a statement.
      load(0, "int ab;", 0, -1);
      for (int k = 0; k <= 3; k++) step();
      do_reset();
      load(0, "int c;", 0, -1);
      for (int k = 0; k <= 7; k++) begin
         step();
         if (k == 7) chk("t5_verdict", {res_valid, res_id, res_ok}, 3'b101);
      end

`ifdef DECL_MAXLEN_EN
      load(0, "int abcde;", 0, -1);
      for (int k = 0; k <= 9; k++) begin
         step();
         chk("t6_err", err, (k == 9));
      end
      load(0, "int abc;", 0, -1);
      for (int k = 0; k <= 9; k++) begin
         step();
         if (k == 9) chk("t6_full_len", {res_valid, res_ok, err}, 3'b110);
      end
`endif

      // Random two-source traffic.
      left[0] = 40; left[1] = 40;
      done = 1'b0;
      for (int c = 0; c < 4000 && !done; c++) begin
         for (int r = 0; r < 2; r++) begin
            if (!active[r] && left[r] > 0) begin
               string s;
               int    st;
               s = pool[$urandom_range(0, 7)];
               st = (s.len() > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, s.len() - 1)) : -1;
               load(r, s, $urandom_range(0, 3), st);
               left[r]--;
            end
         end
         step();
         done = (left[0] == 0 && left[1] == 0 && !active[0] && !active[1]
                 && exp_q.size() == 0 && !busy);
      end
      chk("random_drained", done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
